// File: rtl/rotation_pkg.sv
// Shared definitions for the image-rotation DMA engine: register offsets,
// AHB encodings, FSM state enum, MODE/DIRECTION encodings and the
// quarter-turn helper used by both the register file and the top level.
package rotation_pkg;

    localparam int DIM_W_DEF = 16;

    localparam logic [7:0] REG_SRC        = 8'h00;
    localparam logic [7:0] REG_DST        = 8'h04;
    localparam logic [7:0] REG_HEIGHT     = 8'h08;
    localparam logic [7:0] REG_WIDTH      = 8'h0C;
    localparam logic [7:0] REG_NEW_HEIGHT = 8'h10;
    localparam logic [7:0] REG_NEW_WIDTH  = 8'h14;
    localparam logic [7:0] REG_MODE       = 8'h18;
    localparam logic [7:0] REG_DIRECTION  = 8'h1C;
    localparam logic [7:0] REG_START      = 8'h20;
    localparam logic [7:0] REG_SOFT_RESET = 8'h24;
    localparam logic [7:0] REG_INTR_MASK  = 8'h28;
    localparam logic [7:0] REG_BEF_MASK   = 8'h2C;
    localparam logic [7:0] REG_AFT_MASK   = 8'h30;
    localparam logic [7:0] REG_INTR_CLEAR = 8'h34;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;
    localparam logic [2:0] HBURST_SINGLE = 3'd0;

    localparam logic [1:0] MODE_0   = 2'd0;
    localparam logic [1:0] MODE_90  = 2'd1;
    localparam logic [1:0] MODE_180 = 2'd2;
    localparam logic [1:0] MODE_270 = 2'd3;
    localparam logic       DIR_CCW  = 1'b0;
    localparam logic       DIR_CW   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_DONE
    } state_e;

    // Clockwise quarter turns; a ccw rotation of m quarters is (4-m) mod 4 cw,
    // which is simply the 2-bit negation of m.
    function automatic logic [1:0] quarter_turns(input logic [1:0] mode, input logic dir);
        return (dir == DIR_CW) ? mode : (2'd0 - mode);
    endfunction

endpackage

// File: rtl/rotation_regs.sv
// Register file for the rotation engine.
// Ports: clk/rst (sync active-high), APB slave (paddr[7:0], pwdata, psel,
// penable, pwrite, prdata), busy/done_set from the FSM, start/soft_reset
// strobes to the FSM, configuration outputs (src, dst, height, width,
// quarter-turn count k, new_h, new_w) and the masked done interrupt.
module rotation_regs
    import rotation_pkg::*;
#(
    parameter int DIM_W = DIM_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       paddr,
    input  logic [31:0]      pwdata,
    input  logic             psel,
    input  logic             penable,
    input  logic             pwrite,
    output logic [31:0]      prdata,
    input  logic             busy,
    input  logic             done_set,
    output logic             start,
    output logic             soft_reset,
    output logic [31:0]      src,
    output logic [31:0]      dst,
    output logic [DIM_W-1:0] height,
    output logic [DIM_W-1:0] width,
    output logic [1:0]       k,
    output logic [DIM_W-1:0] new_h,
    output logic [DIM_W-1:0] new_w,
    output logic             intr
);

    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [DIM_W-1:0] height_q, height_d;
    logic [DIM_W-1:0] width_q, width_d;
    logic [1:0]       mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             mask_q, mask_d;
    logic             status_q, status_d;
    logic             wr_en;
    logic             rd_en;
    logic             clear;

    assign wr_en = psel & penable & pwrite;
    assign rd_en = psel & ~pwrite;

    always_comb begin
        src_d      = src_q;
        dst_d      = dst_q;
        height_d   = height_q;
        width_d    = width_q;
        mode_d     = mode_q;
        dir_d      = dir_q;
        mask_d     = mask_q;
        start      = 1'b0;
        soft_reset = 1'b0;
        clear      = 1'b0;
        if (wr_en) begin
            case (paddr)
                REG_SRC:        src_d      = pwdata;
                REG_DST:        dst_d      = pwdata;
                REG_HEIGHT:     height_d   = pwdata[DIM_W-1:0];
                REG_WIDTH:      width_d    = pwdata[DIM_W-1:0];
                REG_MODE:       mode_d     = pwdata[1:0];
                REG_DIRECTION:  dir_d      = pwdata[0];
                REG_START:      start      = pwdata[0];
                REG_SOFT_RESET: soft_reset = pwdata[0];
                REG_INTR_MASK:  mask_d     = pwdata[0];
                REG_INTR_CLEAR: clear      = pwdata[0];
                default: ;
            endcase
        end
        // A completion in the same cycle as a clear must not be lost.
        status_d = status_q;
        if (done_set) begin
            status_d = 1'b1;
        end else if (clear || soft_reset) begin
            status_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q    <= '0;
            dst_q    <= '0;
            height_q <= '0;
            width_q  <= '0;
            mode_q   <= '0;
            dir_q    <= 1'b0;
            mask_q   <= 1'b0;
            status_q <= 1'b0;
        end else begin
            src_q    <= src_d;
            dst_q    <= dst_d;
            height_q <= height_d;
            width_q  <= width_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            mask_q   <= mask_d;
            status_q <= status_d;
        end
    end

    assign src    = src_q;
    assign dst    = dst_q;
    assign height = height_q;
    assign width  = width_q;
    assign k      = quarter_turns(mode_q, dir_q);
    assign new_h  = k[0] ? width_q : height_q;
    assign new_w  = k[0] ? height_q : width_q;
    assign intr   = status_q & ~mask_q;

    always_comb begin
        prdata = '0;
        if (rd_en) begin
            case (paddr)
                REG_SRC:        prdata = src_q;
                REG_DST:        prdata = dst_q;
                REG_HEIGHT:     prdata = 32'(height_q);
                REG_WIDTH:      prdata = 32'(width_q);
                REG_NEW_HEIGHT: prdata = 32'(new_h);
                REG_NEW_WIDTH:  prdata = 32'(new_w);
                REG_MODE:       prdata = {30'd0, mode_q};
                REG_DIRECTION:  prdata = {31'd0, dir_q};
                REG_START:      prdata = {31'd0, busy};
                REG_INTR_MASK:  prdata = {31'd0, mask_q};
                REG_BEF_MASK:   prdata = {31'd0, status_q};
                REG_AFT_MASK:   prdata = {31'd0, intr};
                default:        prdata = '0;
            endcase
        end
    end

endmodule

// File: rtl/rotation_engine.sv
// Image-rotation DMA engine: copies an HxW raster of 32-bit pixels from SRC
// to DST rotated by k clockwise quarter turns, one single-beat AHB read and
// write per pixel, then raises a maskable done interrupt.
// Ports: I_HCLK / I_HRESET (sync active-high); APB register slave
// (I_REG_*, O_REG_PRDATA); AHB master (I_DMA_*, O_DMA_*); O_INTR_DONE.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for START
// REQ      | raise HBUSREQ ahead of the first transfer
// RD_ADDR  | read address phase, held until granted and ready
// RD_DATA  | read data phase, capture pixel on HREADY
// WR_ADDR  | write address phase to the rotated destination
// WR_DATA  | write data phase, then next pixel or finish
// DONE     | set done status, release the bus
module rotation_engine
    import rotation_pkg::*;
#(
    parameter int DIM_W = DIM_W_DEF
) (
    input  logic        I_HCLK,
    input  logic        I_HRESET,
    input  logic [31:0] I_REG_PADDR,
    input  logic [31:0] I_REG_PWDATA,
    input  logic        I_REG_PSEL,
    input  logic        I_REG_PENABLE,
    input  logic        I_REG_PWRITE,
    output logic [31:0] O_REG_PRDATA,
    input  logic [31:0] I_DMA_HRDATA,
    input  logic        I_DMA_HGRANT,
    input  logic        I_DMA_HREADY,
    output logic [31:0] O_DMA_HADDR,
    output logic [31:0] O_DMA_HWDATA,
    output logic [1:0]  O_DMA_HTRANS,
    output logic [2:0]  O_DMA_HSIZE,
    output logic [2:0]  O_DMA_HBURST,
    output logic        O_DMA_HBUSREQ,
    output logic        O_DMA_HWRITE,
    output logic        O_INTR_DONE
);

    localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

    state_e           state_q, state_d;
    logic [DIM_W-1:0] row_q, row_d;
    logic [DIM_W-1:0] col_q, col_d;
    logic [31:0]      pixel_q, pixel_d;

    logic [31:0]      src_base, dst_base;
    logic [DIM_W-1:0] height, width, new_h, new_w;
    logic [1:0]       k;
    logic             start, soft_reset, done_set, busy;
    logic [23:0]      unused_paddr_hi;

    logic [DIM_W-1:0] h_m1_r, w_m1_c, dst_row, dst_col;
    logic [31:0]      src_addr, dst_addr;
    logic             last_col, last_row;

    assign unused_paddr_hi = I_REG_PADDR[31:8];
    assign busy = (state_q != ST_IDLE);

    rotation_regs #(.DIM_W(DIM_W)) u_regs (
        .clk        (I_HCLK),
        .rst        (I_HRESET),
        .paddr      (I_REG_PADDR[7:0]),
        .pwdata     (I_REG_PWDATA),
        .psel       (I_REG_PSEL),
        .penable    (I_REG_PENABLE),
        .pwrite     (I_REG_PWRITE),
        .prdata     (O_REG_PRDATA),
        .busy       (busy),
        .done_set   (done_set),
        .start      (start),
        .soft_reset (soft_reset),
        .src        (src_base),
        .dst        (dst_base),
        .height     (height),
        .width      (width),
        .k          (k),
        .new_h      (new_h),
        .new_w      (new_w),
        .intr       (O_INTR_DONE)
    );

    // Source/destination addresses of the current pixel (row_q, col_q).
    always_comb begin
        h_m1_r = height - DIM_ONE - row_q;
        w_m1_c = width - DIM_ONE - col_q;
        case (k)
            2'd1:    begin dst_row = col_q;  dst_col = h_m1_r; end
            2'd2:    begin dst_row = h_m1_r; dst_col = w_m1_c; end
            2'd3:    begin dst_row = w_m1_c; dst_col = row_q;  end
            default: begin dst_row = row_q;  dst_col = col_q;  end
        endcase
        src_addr = src_base + ((32'(row_q) * 32'(width) + 32'(col_q)) << 2);
        dst_addr = dst_base + ((32'(dst_row) * 32'(new_w) + 32'(dst_col)) << 2);
        last_col = (col_q == width - DIM_ONE);
        last_row = (row_q == height - DIM_ONE);
    end

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        pixel_d       = pixel_q;
        done_set      = 1'b0;
        O_DMA_HBUSREQ = 1'b0;
        O_DMA_HTRANS  = HTRANS_IDLE;
        O_DMA_HWRITE  = 1'b0;
        O_DMA_HADDR   = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = (height == '0 || width == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                O_DMA_HBUSREQ = 1'b1;
                state_d       = ST_RD_ADDR;
            end
            ST_RD_ADDR: begin
                O_DMA_HBUSREQ = 1'b1;
                O_DMA_HADDR   = src_addr;
                if (I_DMA_HGRANT) begin
                    O_DMA_HTRANS = HTRANS_NONSEQ;
                    if (I_DMA_HREADY) state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                O_DMA_HBUSREQ = 1'b1;
                O_DMA_HADDR   = src_addr;
                if (I_DMA_HREADY) begin
                    pixel_d = I_DMA_HRDATA;
                    state_d = ST_WR_ADDR;
                end
            end
            ST_WR_ADDR: begin
                O_DMA_HBUSREQ = 1'b1;
                O_DMA_HWRITE  = 1'b1;
                O_DMA_HADDR   = dst_addr;
                if (I_DMA_HGRANT) begin
                    O_DMA_HTRANS = HTRANS_NONSEQ;
                    if (I_DMA_HREADY) state_d = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                O_DMA_HBUSREQ = 1'b1;
                O_DMA_HWRITE  = 1'b1;
                O_DMA_HADDR   = dst_addr;
                if (I_DMA_HREADY) begin
                    if (!last_col) begin
                        col_d   = col_q + DIM_ONE;
                        state_d = ST_RD_ADDR;
                    end else if (!last_row) begin
                        col_d   = '0;
                        row_d   = row_q + DIM_ONE;
                        state_d = ST_RD_ADDR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_set = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Soft reset aborts mid-transfer and must not leave a stale completion.
        if (soft_reset) begin
            state_d  = ST_IDLE;
            row_d    = '0;
            col_d    = '0;
            done_set = 1'b0;
        end
    end

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            pixel_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pixel_q <= pixel_d;
        end
    end

    assign O_DMA_HWDATA = pixel_q;
    assign O_DMA_HSIZE  = HSIZE_WORD;
    assign O_DMA_HBURST = HBURST_SINGLE;

endmodule

// File: tb/tb_rotation_engine.sv
// Self-checking bench for rotation_engine: an AHB slave model records every
// completed read/write, and a reference model derives the expected transfer
// sequence by rotating each raster coordinate one quarter turn at a time.
module tb_rotation_engine;

    localparam logic [31:0] A_SRC = 32'h00, A_DST = 32'h04, A_H = 32'h08, A_W = 32'h0C;
    localparam logic [31:0] A_NH = 32'h10, A_NW = 32'h14, A_MODE = 32'h18, A_DIR = 32'h1C;
    localparam logic [31:0] A_START = 32'h20, A_SOFT = 32'h24, A_MASK = 32'h28;
    localparam logic [31:0] A_BEF = 32'h2C, A_AFT = 32'h30, A_CLR = 32'h34;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite;
    logic [31:0] hrdata, haddr, hwdata;
    logic        hgrant, hready, hbusreq, hwrite, intr;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;

    always #5 clk = ~clk;

    rotation_engine dut (
        .I_HCLK        (clk),
        .I_HRESET      (rst),
        .I_REG_PADDR   (paddr),
        .I_REG_PWDATA  (pwdata),
        .I_REG_PSEL    (psel),
        .I_REG_PENABLE (penable),
        .I_REG_PWRITE  (pwrite),
        .O_REG_PRDATA  (prdata),
        .I_DMA_HRDATA  (hrdata),
        .I_DMA_HGRANT  (hgrant),
        .I_DMA_HREADY  (hready),
        .O_DMA_HADDR   (haddr),
        .O_DMA_HWDATA  (hwdata),
        .O_DMA_HTRANS  (htrans),
        .O_DMA_HSIZE   (hsize),
        .O_DMA_HBURST  (hburst),
        .O_DMA_HBUSREQ (hbusreq),
        .O_DMA_HWRITE  (hwrite),
        .O_INTR_DONE   (intr)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- AHB slave model ----------------
    int          bus_mode;      // 0: always ready/granted, 1: random stalls, 2: driven by main sequence
    bit          fixed_en;
    logic [31:0] fixed_val, salt;
    logic        pend_v, pend_w;
    logic [31:0] pend_a;
    logic [31:0] rd_q[$], wr_a_q[$], wr_d_q[$], saved_q[$];

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return fixed_en ? fixed_val : ((a * 32'h9E3779B1) ^ salt);
    endfunction

    always_comb hrdata = fixed_en ? fixed_val : ((pend_a * 32'h9E3779B1) ^ salt);

    always @(posedge clk) begin
        if (rst) begin
            pend_v <= 1'b0;
        end else if (hready) begin
            if (pend_v) begin
                if (pend_w) begin
                    wr_a_q.push_back(pend_a);
                    wr_d_q.push_back(hwdata);
                end else begin
                    rd_q.push_back(pend_a);
                end
            end
            pend_v <= (htrans == 2'd2);
            if (htrans == 2'd2) begin
                pend_a <= haddr;
                pend_w <= hwrite;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (bus_mode == 0) begin
            hgrant = 1'b1;
            hready = 1'b1;
        end else if (bus_mode == 1) begin
            hgrant = ($urandom_range(0, 3) != 0);
            hready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_dst(input logic [31:0] dst, input int h, input int w,
                                              input int mode, input int dir, input int r, input int c);
        int k, row, col, hh, ww, t;
        k = dir ? mode : (4 - mode) % 4;
        row = r; col = c; hh = h; ww = w;
        for (int i = 0; i < k; i++) begin
            t = row; row = col; col = hh - 1 - t;
            t = hh; hh = ww; ww = t;
        end
        return dst + 32'(4 * (row * ww + col));
    endfunction

    // ---------------- APB helpers (called at a negedge) ----------------
    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
        #1;
        d = prdata;
        psel = 1'b0; paddr = '0;
    endtask

    task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic program_op(input logic [31:0] src, input logic [31:0] dst, input int h,
                              input int w, input int mode, input int dir);
        apb_write(A_SRC, src);
        apb_write(A_DST, dst);
        apb_write(A_H, 32'(h));
        apb_write(A_W, 32'(w));
        apb_write(A_MODE, 32'(mode));
        apb_write(A_DIR, 32'(dir));
    endtask

    task automatic clear_queues();
        rd_q.delete(); wr_a_q.delete(); wr_d_q.delete();
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] d;
        bit done = 0;
        for (int i = 0; i < 3000; i++) begin
            apb_read(A_START, d);
            if (d == 32'd0) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        check({tag, ":completes"}, 32'(done), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] src, input logic [31:0] dst,
                          input int h, input int w, input int mode, input int dir);
        program_op(src, dst, h, w, mode, dir);
        clear_queues();
        apb_write(A_START, 32'd1);
        wait_idle(tag);
    endtask

    task automatic verify(input string tag, input logic [31:0] src, input logic [31:0] dst,
                          input int h, input int w, input int mode, input int dir);
        int n;
        logic [31:0] es, ed;
        n = h * w;
        check({tag, ":rd_count"}, 32'(rd_q.size()), 32'(n));
        check({tag, ":wr_count"}, 32'(wr_a_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            es = src + 32'(4 * i);
            ed = model_dst(dst, h, w, mode, dir, i / w, i % w);
            if (i < rd_q.size()) check($sformatf("%s:rd_addr%0d", tag, i), rd_q[i], es);
            if (i < wr_a_q.size()) begin
                check($sformatf("%s:wr_addr%0d", tag, i), wr_a_q[i], ed);
                check($sformatf("%s:wr_data%0d", tag, i), wr_d_q[i], data_of(es));
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] src, dst;
        int h, w, mode, dir, k;

        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        hgrant = 1'b0; hready = 1'b0; bus_mode = 0; fixed_en = 0; fixed_val = '0;
        salt = 32'h1357_9BDF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst:prdata", prdata, 32'd0);
        check("rst:haddr", haddr, 32'd0);
        check("rst:hwdata", hwdata, 32'd0);
        check("rst:htrans", 32'(htrans), 32'd0);
        check("rst:hbusreq", 32'(hbusreq), 32'd0);
        check("rst:hwrite", 32'(hwrite), 32'd0);
        check("rst:intr", 32'(intr), 32'd0);
        check("rst:hsize", 32'(hsize), 32'd2);
        check("rst:hburst", 32'(hburst), 32'd0);
        check_reg("rst:src", A_SRC, 32'd0);
        check_reg("rst:start", A_START, 32'd0);

        @(negedge clk);
        apb_write(A_H, 32'hFFFF_1234);
        check_reg("reg:height_trunc", A_H, 32'h0000_1234);
        apb_write(32'h38, 32'hDEAD_BEEF);
        check_reg("reg:unmapped", 32'h38, 32'd0);
        apb_write(A_SRC, 32'hCAFE_0004);
        check_reg("reg:src_rw", A_SRC, 32'hCAFE_0004);

        // 1x1 copy with a fixed pixel value
        fixed_en = 1; fixed_val = 32'hA5A5_A5A5;
        run_op("t1", 32'h1000, 32'h2000, 1, 1, 0, 1);
        verify("t1", 32'h1000, 32'h2000, 1, 1, 0, 1);
        check_reg("t1:bef_mask", A_BEF, 32'd1);
        check("t1:intr", 32'(intr), 32'd1);
        apb_write(A_CLR, 32'd1);
        #1;
        check("t1:intr_cleared", 32'(intr), 32'd0);
        fixed_en = 0;

        // 2x3 rotated 90 cw with random bus stalls
        bus_mode = 1;
        run_op("t2", 32'h0001_0000, 32'h0002_0000, 2, 3, 1, 1);
        verify("t2", 32'h0001_0000, 32'h0002_0000, 2, 3, 1, 1);
        check_reg("t2:new_h", A_NH, 32'd3);
        check_reg("t2:new_w", A_NW, 32'd2);
        if (wr_a_q.size() > 5) begin
            check("t2:pix00", wr_a_q[0], 32'h0002_0004);
            check("t2:pix12", wr_a_q[5], 32'h0002_0010);
        end

        run_op("t3a", 32'h0001_0000, 32'h0002_0000, 2, 3, 2, 1);
        verify("t3a", 32'h0001_0000, 32'h0002_0000, 2, 3, 2, 1);
        if (wr_a_q.size() > 0) check("t3a:pix00", wr_a_q[0], 32'h0002_0014);
        run_op("t3b", 32'h0001_0000, 32'h0002_0000, 2, 3, 1, 0);
        verify("t3b", 32'h0001_0000, 32'h0002_0000, 2, 3, 1, 0);
        saved_q = wr_a_q;
        run_op("t3c", 32'h0001_0000, 32'h0002_0000, 2, 3, 3, 1);
        check("t3:ccw_cw_len", 32'(wr_a_q.size()), 32'(saved_q.size()));
        for (int i = 0; i < saved_q.size() && i < wr_a_q.size(); i++)
            check($sformatf("t3:ccw_cw_addr%0d", i), wr_a_q[i], saved_q[i]);

        // grant withheld and ready stalls, driven cycle by cycle
        @(negedge clk);
        bus_mode = 2; hgrant = 1'b0; hready = 1'b0;
        program_op(32'h3000, 32'h4000, 1, 1, 0, 1);
        clear_queues();
        apb_write(A_START, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("t4:nogrant_htrans", 32'(htrans), 32'd0);
            check("t4:nogrant_busreq", 32'(hbusreq), 32'd1);
            check("t4:nogrant_haddr", haddr, 32'h3000);
        end
        hgrant = 1'b1; #1;
        check("t4:grant_htrans", 32'(htrans), 32'd2);
        @(negedge clk); #1;
        check("t4:rdaddr_hold", haddr, 32'h3000);
        check("t4:rdaddr_htrans", 32'(htrans), 32'd2);
        hready = 1'b1;
        @(negedge clk);
        hready = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("t4:rddata_htrans", 32'(htrans), 32'd0);
            check("t4:rddata_haddr", haddr, 32'h3000);
        end
        hready = 1'b1;
        @(negedge clk); #1;
        check("t4:wraddr_htrans", 32'(htrans), 32'd2);
        check("t4:wraddr_hwrite", 32'(hwrite), 32'd1);
        check("t4:wraddr_haddr", haddr, 32'h4000);
        @(negedge clk);
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4:wrdata_hwdata", hwdata, data_of(32'h3000));
            check("t4:wrdata_haddr", haddr, 32'h4000);
            @(negedge clk);
        end
        bus_mode = 0; hready = 1'b1;
        wait_idle("t4");
        verify("t4", 32'h3000, 32'h4000, 1, 1, 0, 1);

        // interrupt mask
        apb_write(A_CLR, 32'd1);
        apb_write(A_MASK, 32'd1);
        bus_mode = 1;
        run_op("t5", 32'h5000, 32'h6000, 2, 2, 3, 0);
        verify("t5", 32'h5000, 32'h6000, 2, 2, 3, 0);
        check_reg("t5:bef_mask", A_BEF, 32'd1);
        check_reg("t5:aft_mask", A_AFT, 32'd0);
        check("t5:intr_masked", 32'(intr), 32'd0);
        apb_write(A_MASK, 32'd0);
        #1;
        check("t5:intr_unmasked", 32'(intr), 32'd1);
        check_reg("t5:aft_unmasked", A_AFT, 32'd1);

        // soft reset during the third pixel (status still set from t5)
        bus_mode = 0;
        @(negedge clk);
        program_op(32'h7000, 32'h8000, 3, 3, 1, 1);
        clear_queues();
        apb_write(A_START, 32'd1);
        begin
            bit seen = 0;
            for (int i = 0; i < 200; i++) begin
                if (wr_a_q.size() >= 2) begin
                    seen = 1;
                    break;
                end
                @(negedge clk);
            end
            check("t6:two_pixels_done", 32'(seen), 32'd1);
        end
        apb_write(A_SOFT, 32'd1);
        #1;
        check("t6:busreq_dropped", 32'(hbusreq), 32'd0);
        check("t6:htrans_idle", 32'(htrans), 32'd0);
        check_reg("t6:start_rb", A_START, 32'd0);
        check_reg("t6:status_cleared", A_BEF, 32'd0);
        repeat (20) @(negedge clk);
        check("t6:wr_count", 32'(wr_a_q.size()), 32'd2);
        check_reg("t6:no_done", A_BEF, 32'd0);
        check_reg("t6:cfg_kept", A_SRC, 32'h7000);

        // zero height: done with no bus activity
        run_op("t7", 32'h9000, 32'hA000, 0, 3, 0, 1);
        check("t7:rd_count", 32'(rd_q.size()), 32'd0);
        check("t7:wr_count", 32'(wr_a_q.size()), 32'd0);
        check_reg("t7:bef_mask", A_BEF, 32'd1);

        // randomized shapes, rotations and base addresses
        bus_mode = 1;
        for (int it = 0; it < 6; it++) begin
            salt = $urandom;
            h = $urandom_range(1, 4);
            w = $urandom_range(1, 4);
            mode = $urandom_range(0, 3);
            dir = $urandom_range(0, 1);
            src = $urandom & 32'hFFFF_FFFC;
            dst = (it == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            run_op($sformatf("rnd%0d", it), src, dst, h, w, mode, dir);
            verify($sformatf("rnd%0d", it), src, dst, h, w, mode, dir);
            k = dir ? mode : (4 - mode) % 4;
            check_reg($sformatf("rnd%0d:new_h", it), A_NH, 32'((k % 2) ? w : h));
            check_reg($sformatf("rnd%0d:new_w", it), A_NW, 32'((k % 2) ? h : w));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
